// File: rtl/fm_source_arbiter.sv
// Multi-source FM deviation arbiter: tracks per-source activity, selects or sums
// sources by mode, scales into a phase increment about CENTER_INC and slew-limits it.
module fm_source_arbiter #(
  parameter int              N_SRC       = 4,
  parameter int              SAMPLE_W    = 16,
  parameter int              ACC_W       = 32,
  parameter int              TIMEOUT_CYC = 255,
  parameter logic [ACC_W-1:0] CENTER_INC = 32'h40000000,
  parameter logic [ACC_W-1:0] DEV_SCALE  = 32'h00009A5E,
  parameter logic [ACC_W-1:0] SLEW_STEP  = 32'h00000000,
  localparam int             IDX_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [IDX_W-1:0]          manual_sel,
  input  logic [N_SRC*SAMPLE_W-1:0] src_sample,
  input  logic [N_SRC-1:0]          src_valid,
  output logic [N_SRC-1:0]          src_active,
  output logic                      sel_valid,
  output logic [IDX_W-1:0]          sel_idx,
  output logic [ACC_W-1:0]          phase_inc,
  output logic                      settled,
  output logic                      carrier_en
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int SUM_W  = SAMPLE_W + IDX_W;
  localparam int PROD_W = SAMPLE_W + ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [SAMPLE_W-1:0] hold [N_SRC];
  logic [CNT_W-1:0]           cnt  [N_SRC];
  logic [N_SRC-1:0]           active;
  logic [ACC_W-1:0]           target;
  logic [ACC_W-1:0]           phase_reg;

  logic                       sel_v;
  logic [IDX_W-1:0]           sel_i;
  logic signed [SAMPLE_W-1:0] sel_s;
  logic signed [SUM_W-1:0]    sum;
  logic                       man_ok;
  logic signed [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]           dev;
  logic [ACC_W-1:0]           target_next;
  logic signed [ACC_W:0]      diff;
  logic [ACC_W:0]             mag;
  logic [ACC_W-1:0]           phase_next;

  // A source stays active TIMEOUT_CYC+1 clocks after its last strobe; a new strobe retriggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold[i] <= '0;
        cnt[i]  <= '0;
      end
    end else if (!enable) begin
      active <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_valid[i]) begin
          hold[i]   <= src_sample[i*SAMPLE_W +: SAMPLE_W];
          cnt[i]    <= CNT_W'(TIMEOUT_CYC);
          active[i] <= 1'b1;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end else begin
          active[i] <= 1'b0;
        end
      end
    end
  end

  assign man_ok = int'(manual_sel) < N_SRC;

  always_comb begin
    sel_v = 1'b0;
    sel_i = '0;
    sel_s = '0;
    sum   = '0;
    case (mode)
      2'd1: begin
        if (man_ok && active[manual_sel]) begin
          sel_v = 1'b1;
          sel_i = manual_sel;
          sel_s = hold[manual_sel];
        end
      end
      2'd2: begin
        for (int i = 0; i < N_SRC; i++) begin
          if (active[i]) sum = sum + SUM_W'(hold[i]);
        end
        sel_v = |active;
        if (sum > SAT_MAX)      sel_s = SAT_MAX[SAMPLE_W-1:0];
        else if (sum < SAT_MIN) sel_s = SAT_MIN[SAMPLE_W-1:0];
        else                    sel_s = sum[SAMPLE_W-1:0];
      end
      default: begin
        // Scan downward so the lowest active index wins.
        for (int i = N_SRC - 1; i >= 0; i--) begin
          if (active[i]) begin
            sel_v = 1'b1;
            sel_i = IDX_W'(i);
            sel_s = hold[i];
          end
        end
      end
    endcase
  end

  // Q16 deviation: floor((sample * DEV_SCALE) / 2^16), wrapped into ACC_W.
  assign prod        = PROD_W'(sel_s) * PROD_W'($signed({1'b0, DEV_SCALE}));
  assign dev         = ACC_W'(prod >>> 16);
  assign target_next = enable ? (CENTER_INC + dev) : CENTER_INC;

  assign diff = $signed({1'b0, target}) - $signed({1'b0, phase_reg});
  assign mag  = diff[ACC_W] ? $unsigned(-diff) : $unsigned(diff);

  always_comb begin
    phase_next = target;
    if ((SLEW_STEP != '0) && (mag > {1'b0, SLEW_STEP})) begin
      phase_next = diff[ACC_W] ? (phase_reg - SLEW_STEP) : (phase_reg + SLEW_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target    <= CENTER_INC;
      phase_reg <= CENTER_INC;
    end else begin
      target    <= target_next;
      phase_reg <= phase_next;
    end
  end

  assign src_active = active;
  assign sel_valid  = sel_v;
  assign sel_idx    = sel_i;
  assign phase_inc  = phase_reg;
  assign settled    = (phase_reg == target);
  assign carrier_en = enable & (|active);

endmodule

// File: tb/tb_fm_source_arbiter.sv
// Bench for fm_source_arbiter: an unlimited-slew and a slew-limited instance share
// stimulus and are checked every clock against a timestamp-based behavioural model.
module tb_fm_source_arbiter;

  localparam int          TO     = 255;
  localparam int          NEVER  = -100000;
  localparam logic [31:0] CENTER = 32'h40000000;
  localparam logic [31:0] DEV    = 32'h00009A5E;
  localparam logic [31:0] STEP1  = 32'h00001000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  manual_sel = 2'd0;
  logic [63:0] src_sample = '0;
  logic [3:0]  src_valid = '0;

  logic [3:0]  act0, act1;
  logic        sv0, sv1, st0, st1, ce0, ce1;
  logic [1:0]  si0, si1;
  logic [31:0] ph0, ph1;

  int errors = 0;
  int checks = 0;

  // Model state: edge count, edge of each source's last strobe, held samples.
  int                 m_k = 0;
  int                 m_last [4] = '{default: NEVER};
  logic signed [15:0] m_hold [4] = '{default: '0};
  logic [31:0]        m_tgt = CENTER;
  logic [31:0]        m_ph [2] = '{default: CENTER};

  always #5 clk = ~clk;

  fm_source_arbiter #(.SLEW_STEP(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .manual_sel(manual_sel),
    .src_sample(src_sample), .src_valid(src_valid), .src_active(act0), .sel_valid(sv0),
    .sel_idx(si0), .phase_inc(ph0), .settled(st0), .carrier_en(ce0));

  fm_source_arbiter #(.SLEW_STEP(STEP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .manual_sel(manual_sel),
    .src_sample(src_sample), .src_valid(src_valid), .src_active(act1), .sel_valid(sv1),
    .sel_idx(si1), .phase_inc(ph1), .settled(st1), .carrier_en(ce1));

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit mAct(input int i);
    return (m_last[i] != NEVER) && ((m_k - m_last[i]) <= TO);
  endfunction

  task automatic mSel(output bit v, output int idx, output int s);
    int sum;
    v = 1'b0; idx = 0; s = 0; sum = 0;
    if (mode == 2'd2) begin
      for (int i = 0; i < 4; i++) if (mAct(i)) begin v = 1'b1; sum += int'(m_hold[i]); end
      s = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
    end else if (mode == 2'd1) begin
      if (mAct(int'(manual_sel))) begin
        v = 1'b1; idx = int'(manual_sel); s = int'(m_hold[manual_sel]);
      end
    end else begin
      for (int i = 3; i >= 0; i--) if (mAct(i)) begin v = 1'b1; idx = i; s = int'(m_hold[i]); end
    end
  endtask

  function automatic logic [31:0] mTarget(input int s);
    longint p;
    p = longint'(s) * longint'(DEV);
    return CENTER + 32'(p >>> 16);
  endfunction

  function automatic logic [31:0] mSlew(input logic [31:0] ph, input logic [31:0] tg,
                                        input logic [31:0] step);
    longint d, a;
    d = longint'(tg) - longint'(ph);
    a = (d < 0) ? -d : d;
    if (step == 0 || a <= longint'(step)) return tg;
    return (d > 0) ? ph + step : ph - step;
  endfunction

  // Model update on each edge, then compare both instances just after it.
  always @(posedge clk) begin
    bit v; int idx, s; logic [3:0] e_act; bit any;
    if (!rst_n) begin
      m_k = 0;
      for (int i = 0; i < 4; i++) begin m_last[i] = NEVER; m_hold[i] = '0; end
      m_tgt = CENTER; m_ph[0] = CENTER; m_ph[1] = CENTER;
    end else begin
      mSel(v, idx, s);
      m_ph[0] = mSlew(m_ph[0], m_tgt, 32'h0);
      m_ph[1] = mSlew(m_ph[1], m_tgt, STEP1);
      m_tgt   = enable ? mTarget(v ? s : 0) : CENTER;
      m_k++;
      for (int i = 0; i < 4; i++) begin
        if (!enable) begin
          m_last[i] = NEVER; m_hold[i] = '0;
        end else if (src_valid[i]) begin
          m_last[i] = m_k; m_hold[i] = src_sample[i*16 +: 16];
        end
      end
    end
    #1;
    mSel(v, idx, s);
    for (int i = 0; i < 4; i++) e_act[i] = mAct(i);
    any = |e_act;
    checkOutput("src_active0", 32'(act0), 32'(e_act));
    checkOutput("src_active1", 32'(act1), 32'(e_act));
    checkOutput("sel_valid0", 32'(sv0), 32'(v));
    checkOutput("sel_valid1", 32'(sv1), 32'(v));
    checkOutput("sel_idx0", 32'(si0), 32'(idx));
    checkOutput("sel_idx1", 32'(si1), 32'(idx));
    checkOutput("phase_inc0", ph0, m_ph[0]);
    checkOutput("phase_inc1", ph1, m_ph[1]);
    checkOutput("settled0", 32'(st0), 32'(m_ph[0] == m_tgt));
    checkOutput("settled1", 32'(st1), 32'(m_ph[1] == m_tgt));
    checkOutput("carrier_en0", 32'(ce0), 32'(enable & any));
    checkOutput("carrier_en1", 32'(ce1), 32'(enable & any));
  end

  // One-clock strobe; returns on the falling edge after the sampling edge.
  task automatic applyStimulus(input logic [3:0] valid, input logic [63:0] samples);
    @(negedge clk);
    src_valid  = valid;
    src_sample = samples;
    @(negedge clk);
    src_valid  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearAll();
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
  endtask

  initial begin
    int hi;
    idle(3);
    checkOutput("reset_phase_inc", ph0, CENTER);
    checkOutput("reset_active", 32'(act0), 32'h0);
    checkOutput("reset_settled", 32'(st0), 32'h1);
    checkOutput("reset_carrier", 32'(ce0), 32'h0);
    checkOutput("reset_sel_valid", 32'(sv0), 32'h0);
    rst_n = 1'b1; enable = 1'b1; mode = 2'd0;

    applyStimulus(4'b0010, 64'h0000_0000_4000_0000);
    checkOutput("t1_active", 32'(act0), 32'h2);
    checkOutput("t1_sel_idx", 32'(si0), 32'h1);
    idle(2);
    checkOutput("t1_phase_inc", ph0, 32'h40002697);
    checkOutput("slew_step1", ph1, 32'h40001000);
    checkOutput("slew_unsettled", 32'(st1), 32'h0);
    idle(1);
    checkOutput("slew_step2", ph1, 32'h40002000);
    idle(1);
    checkOutput("slew_step3", ph1, 32'h40002697);
    checkOutput("slew_settled", 32'(st1), 32'h1);

    applyStimulus(4'b0010, 64'h0000_0000_C000_0000);
    idle(2);
    checkOutput("neg_phase_inc", ph0, 32'h3FFFD968);
    applyStimulus(4'b0001, 64'h0);
    checkOutput("prio_sel_idx", 32'(si0), 32'h0);
    idle(2);
    checkOutput("prio_phase_inc", ph0, CENTER);

    mode = 2'd2;
    applyStimulus(4'b0011, 64'h0000_0000_7000_7000);
    checkOutput("sum_sel_idx", 32'(si0), 32'h0);
    idle(2);
    checkOutput("sum_sat_phase_inc", ph0, 32'h40004D2E);

    mode = 2'd0;
    clearAll();
    applyStimulus(4'b0100, 64'h0000_0100_0000_0000);
    hi = 0;
    for (int c = 0; c < 400 && act0[2]; c++) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("timeout_high_clocks", 32'(hi), 32'd256);
    checkOutput("timeout_sel_valid", 32'(sv0), 32'h0);
    checkOutput("timeout_carrier", 32'(ce0), 32'h0);
    idle(2);
    checkOutput("timeout_phase_inc", ph0, CENTER);

    clearAll();
    mode = 2'd1; manual_sel = 2'd3;
    applyStimulus(4'b0001, 64'h0000_0000_0000_4000);
    checkOutput("manual_sel_valid", 32'(sv0), 32'h0);
    idle(2);
    checkOutput("manual_phase_inc", ph0, CENTER);
    checkOutput("manual_carrier", 32'(ce0), 32'h1);
    mode = 2'd0;
    idle(2);
    checkOutput("midslew_phase_inc", ph1, 32'h40001000);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_phase_inc1", ph1, CENTER);
    checkOutput("rst_phase_inc0", ph0, CENTER);
    checkOutput("rst_active", 32'(act1), 32'h0);
    checkOutput("rst_settled", 32'(st1), 32'h1);
    checkOutput("rst_sel_valid", 32'(sv1), 32'h0);
    checkOutput("rst_sel_idx", 32'(si1), 32'h0);
    checkOutput("rst_carrier", 32'(ce1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
